// File: rtl/gpr_ctrl_pkg.sv
// Shared types for the GPR write-port controller: write request record and
// starvation FSM states.
package gpr_ctrl_pkg;
  localparam int NREG = 32;
  localparam int RW_W = 5;
  localparam int DW   = 32;

  typedef struct packed {
    logic [RW_W-1:0] rw;
    logic [DW-1:0]   wd;
  } wb_req_t;

  typedef enum logic [1:0] {IDLE, WAIT, HOLD} starve_state_t;
endpackage

// File: rtl/md_wb_fifo.sv
// Synchronous FIFO buffering MD results until the GPR write port is free.
// Pointers carry one extra wrap bit so full/empty need no occupancy counter.
module md_wb_fifo
  import gpr_ctrl_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic    clk,
  input  logic    reset,
  input  logic    push_i,
  input  wb_req_t din_i,
  input  logic    pop_i,
  output wb_req_t dout_o,
  output logic    full_o,
  output logic    empty_o
);
  localparam int AW = $clog2(DEPTH);

  wb_req_t       mem_q [DEPTH];
  logic [AW:0]   wr_q, rd_q;

  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign dout_o  = mem_q[rd_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (push_i && !full_o) begin
        mem_q[wr_q[AW-1:0]] <= din_i;
        wr_q                <= wr_q + 1'b1;
      end
      if (pop_i && !empty_o)
        rd_q <= rd_q + 1'b1;
    end
  end
endmodule

// File: rtl/gpr_wb_arbiter.sv
// Shares the single GPR write port between pipeline WB and buffered MD results,
// tracks in-flight MD destinations and forces a one-cycle hold when MD starves.
module gpr_wb_arbiter
  import gpr_ctrl_pkg::*;
#(
  parameter int DEPTH      = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            wb_we,
  input  logic [RW_W-1:0] wb_rw,
  input  logic [DW-1:0]   wb_wd,
  input  logic            md_valid,
  output logic            md_ready,
  input  logic [RW_W-1:0] md_rw,
  input  logic [DW-1:0]   md_wd,
  input  logic            md_issue,
  input  logic [RW_W-1:0] md_issue_rw,
  input  logic [RW_W-1:0] id_rs,
  input  logic [RW_W-1:0] id_rt,
  output logic            id_stall,
  output logic            pipe_hold,
  output logic            regWrite,
  output logic [RW_W-1:0] rw,
  output logic [DW-1:0]   Wd,
  output logic [NREG-1:0] pending
);
  wb_req_t       head, md_req;
  logic          fifo_full, fifo_empty;
  logic          push, drain, wb_sel, blocked;
  starve_state_t state_q;
  logic [2:0]    cnt_q;
  logic          hold_q;
  logic [NREG-1:0] pending_q, pending_d;

  assign md_req    = '{rw: md_rw, wd: md_wd};
  assign pipe_hold = hold_q & ~reset;
  assign md_ready  = ~reset & ~fifo_full;
  assign push      = md_valid & md_ready;
  // WB owns the port unless the pipeline is frozen; the buffer gets leftovers.
  assign wb_sel    = ~reset & ~hold_q & wb_we;
  assign drain     = ~reset & ~wb_sel & ~fifo_empty;
  assign blocked   = wb_sel & ~fifo_empty;
  assign pending   = pending_q;

  md_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .din_i   (md_req),
    .pop_i   (drain),
    .dout_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_comb begin
    regWrite = 1'b0;
    rw       = '0;
    Wd       = '0;
    if (wb_sel) begin
      regWrite = (wb_rw != '0);
      rw       = wb_rw;
      Wd       = wb_wd;
    end else if (drain) begin
      regWrite = (head.rw != '0);
      rw       = head.rw;
      Wd       = head.wd;
    end
  end

  // Clear first so a same-cycle issue to the drained register stays pending.
  always_comb begin
    pending_d = pending_q;
    if (drain)
      pending_d[head.rw] = 1'b0;
    if (md_issue && (md_issue_rw != '0))
      pending_d[md_issue_rw] = 1'b1;
  end

  assign id_stall = ~reset & (
      (pending_q[id_rs] && (id_rs != '0)) ||
      (pending_q[id_rt] && (id_rt != '0)) ||
      (md_issue && pending_q[md_issue_rw]));

  always_ff @(posedge clk) begin
    if (reset) pending_q <= '0;
    else       pending_q <= pending_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hold_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          hold_q <= 1'b0;
          if (blocked) begin
            cnt_q <= 3'd1;
            if (STARVE_MAX <= 1) begin
              state_q <= HOLD;
              hold_q  <= 1'b1;
            end else begin
              state_q <= WAIT;
            end
          end
        end
        WAIT: begin
          if (blocked) begin
            cnt_q <= cnt_q + 3'd1;
            if (int'(cnt_q) + 1 >= STARVE_MAX) begin
              state_q <= HOLD;
              hold_q  <= 1'b1;
            end
          end else begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end
        end
        HOLD: begin
          state_q <= IDLE;
          cnt_q   <= '0;
          hold_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
          hold_q  <= 1'b0;
        end
      endcase
    end
  end
endmodule
